// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry full adder.
package full_adder_pkg;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell, the leaf of the ripple-carry chain.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    logic w_p;

    // Propagate term is shared between sum and carry.
    assign w_p  = i_a ^ i_b;
    assign o_s  = w_p ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout,s} <= a + b + cin, one cycle latency.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .i_a  (a[gi]),
                .i_b  (b[gi]),
                .i_ci (w_carry[gi]),
                .o_s  (w_sum[gi]),
                .o_co (w_carry[gi+1])
            );
        end
    endgenerate

    // Reset clears immediately so the outputs are never undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign s    = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=4 against an arithmetic reference.
module tb_full_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, cin1, s1, cout1;
    logic [3:0] a4, b4, s4;
    logic       cin4, cout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4)
    );

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #1;
        checks++;
        if ({cout1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_t0_w1: got %b expected 00", {cout1, s1});
        end
        checks++;
        if ({cout4, s4} !== 5'h00) begin
            errors++;
            $display("FAIL reset_t0_w4: got %h expected 00", {cout4, s4});
        end
        @(posedge clk); #1;
        checks++;
        if ({cout1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold_w1: got %b expected 00", {cout1, s1});
        end
        checks++;
        if ({cout4, s4} !== 5'h00) begin
            errors++;
            $display("FAIL reset_hold_w4: got %h expected 00", {cout4, s4});
        end
        $display("reset: outputs zero at t=0 and while rst high");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            exp = 2'(int'(a1) + int'(b1) + int'(cin1));
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({cout1, s1} !== exp) begin
                    errors++;
                    $display("FAIL exhaustive v=%0d k=%0d: got %b expected %b", v, k, {cout1, s1}, exp);
                end
            end
            $display("exhaustive: abc=%0d%0d%0d -> cout,s=%b", a1, b1, cin1, {cout1, s1});
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk); #1;
        a1 = 1'b1;
        #1;
        checks++;
        if (s1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_after_change: got %b expected 0", s1);
        end
        @(negedge clk);
        checks++;
        if (s1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_midcycle: got %b expected 0", s1);
        end
        @(posedge clk); #1;
        checks++;
        if ({cout1, s1} !== 2'b01) begin
            errors++;
            $display("FAIL latency_next_edge: got %b expected 01", {cout1, s1});
        end
        $display("latency: s rose one edge after a changed, s=%b", s1);
    endtask

    task automatic test_midrun_reset();
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cout1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_before: got %b expected 11", {cout1, s1});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cout1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_immediate: got %b expected 00", {cout1, s1});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cout1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_after_release: got %b expected 00", {cout1, s1});
        end
        @(posedge clk); #1;
        checks++;
        if ({cout1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_reload: got %b expected 11", {cout1, s1});
        end
        $display("midrun reset: dropped to 00, reloaded %b", {cout1, s1});
    endtask

    task automatic test_boundary_w4();
        logic [3:0] ta [3] = '{4'hF, 4'hF, 4'h0};
        logic [3:0] tb [3] = '{4'h1, 4'hF, 4'h0};
        logic       tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [4:0] exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
            exp = 5'(int'(a4) + int'(b4) + int'(cin4));
            @(posedge clk); #1;
            checks++;
            if ({cout4, s4} !== exp) begin
                errors++;
                $display("FAIL boundary_w4 %h+%h+%b: got %h expected %h", a4, b4, cin4, {cout4, s4}, exp);
            end
            $display("boundary: %h+%h+%b -> cout=%b s=%h", a4, b4, cin4, cout4, s4);
        end
    endtask

    task automatic test_random_w4();
        logic [4:0] exp;
        int         ra, rb, rc;
        int         bad = 0;
        @(negedge clk);
        a4 = 4'($urandom_range(15)); b4 = 4'($urandom_range(15)); cin4 = 1'($urandom_range(1));
        exp = 5'(int'(a4) + int'(b4) + int'(cin4));
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({cout4, s4} !== exp) begin
                errors++; bad++;
                $display("FAIL random_w4 n=%0d: got %h expected %h", n, {cout4, s4}, exp);
            end
            // Disturb inputs between edges; the registered outputs must not move.
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            #2;
            checks++;
            if ({cout4, s4} !== exp) begin
                errors++; bad++;
                $display("FAIL random_hold n=%0d: got %h expected %h", n, {cout4, s4}, exp);
            end
            @(negedge clk);
            ra = int'($urandom_range(15)); rb = int'($urandom_range(15)); rc = int'($urandom_range(1));
            a4 = 4'(ra); b4 = 4'(rb); cin4 = 1'(rc);
            exp = 5'(ra + rb + rc);
        end
        $display("random: 1000 vectors, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_exhaustive_w1();
        test_latency();
        test_midrun_reset();
        test_boundary_w4();
        test_random_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
